// File: rtl/ysyx_22050598_cache_pkg.sv
// Shared constants, controller state encoding and address helpers for the instruction cache.
package ysyx_22050598_cache_pkg;

  localparam int AW = 64;
  localparam int OW = 4;
  localparam int IW = 6;
  localparam int TW = AW - IW - OW;
  localparam int DW = TW + 1;
  localparam int LW = 128;
  localparam int XW = 64;
  localparam int VB = DW - 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_MISS,
    S_REFILL,
    S_WRITE,
    S_RESP,
    S_FLUSH
  } state_t;

  function automatic logic [TW-1:0] addr_tag(input logic [AW-1:0] a);
    return a[AW-1:OW+IW];
  endfunction

endpackage

// File: rtl/ysyx_22050598_cache_refill_buf.sv
// Collects a two-beat refill (low doubleword first) into one line; done flags the rlast beat.
// Zero latency on o_done, line register updates on the beat edge; no backpressure toward memory.
module ysyx_22050598_cache_refill_buf
  import ysyx_22050598_cache_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clr,
  input  logic          i_beat_vld,
  input  logic [XW-1:0] i_beat_dat,
  input  logic          i_beat_last,
  output logic          o_done,
  output logic [LW-1:0] o_line
);

  logic          r_cnt;
  logic [LW-1:0] r_line;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt  <= 1'b0;
      r_line <= '0;
    end else if (i_clr) begin
      r_cnt <= 1'b0;
    end else if (i_beat_vld) begin
      if (r_cnt) r_line[LW-1:XW] <= i_beat_dat;
      else       r_line[XW-1:0]  <= i_beat_dat;
      r_cnt <= ~r_cnt;
    end
  end

  assign o_done = i_beat_vld & i_beat_last;
  assign o_line = r_line;

endmodule

// File: rtl/ysyx_22050598_icache_ctrl.sv
// Direct-mapped I-cache controller: hit response 2 cycles after request, miss refills 2 beats then writes.
// Holds cpu_req_ready low while busy and holds the response until cpu_resp_ready.
module ysyx_22050598_icache_ctrl
  import ysyx_22050598_cache_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req_valid,
  output logic          cpu_req_ready,
  input  logic [AW-1:0] cpu_req_addr,
  output logic          cpu_resp_valid,
  input  logic          cpu_resp_ready,
  output logic [XW-1:0] cpu_resp_data,
  input  logic          fence_i,
  output logic          fence_done,
  output logic [IW-1:0] set_index,
  output logic          tag_wen,
  output logic [DW-1:0] tag_wdata,
  input  logic [DW-1:0] tag_rdata,
  output logic          data_wen,
  output logic [LW-1:0] data_wdata,
  input  logic [LW-1:0] data_rdata,
  output logic          mem_arvalid,
  input  logic          mem_arready,
  output logic [AW-1:0] mem_araddr,
  input  logic          mem_rvalid,
  input  logic [XW-1:0] mem_rdata,
  input  logic          mem_rlast
);

  state_t        r_state;
  logic [AW-1:0] r_addr;
  logic [IW-1:0] r_cnt;
  logic          r_req_rdy, r_resp_vld, r_fence_done, r_arvalid, r_tag_wen, r_data_wen;
  logic [XW-1:0] r_resp_dat;
  logic [AW-1:0] r_araddr;
  logic [DW-1:0] r_tag_wdata;

  logic          w_hit, w_done;
  logic [XW-1:0] w_hit_dw, w_fill_dw;
  logic [LW-1:0] w_line;
  logic          w_unused;

  assign w_hit     = tag_rdata[VB] && (tag_rdata[TW-1:0] == addr_tag(r_addr));
  assign w_hit_dw  = r_addr[3] ? data_rdata[LW-1:XW] : data_rdata[XW-1:0];
  assign w_fill_dw = r_addr[3] ? w_line[LW-1:XW] : w_line[XW-1:0];
  assign w_unused  = ^r_addr[2:0];

  ysyx_22050598_cache_refill_buf u_refill_buf (
    .clk         (clk),
    .rst         (rst),
    .i_clr       (r_state != S_REFILL),
    .i_beat_vld  ((r_state == S_REFILL) && mem_rvalid),
    .i_beat_dat  (mem_rdata),
    .i_beat_last (mem_rlast),
    .o_done      (w_done),
    .o_line      (w_line)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_cnt        <= '0;
      r_req_rdy    <= 1'b1;
      r_resp_vld   <= 1'b0;
      r_resp_dat   <= '0;
      r_fence_done <= 1'b0;
      r_arvalid    <= 1'b0;
      r_araddr     <= '0;
      r_tag_wen    <= 1'b0;
      r_data_wen   <= 1'b0;
      r_tag_wdata  <= '0;
    end else begin
      r_fence_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // fence wins over a simultaneous request, which is left unaccepted
          if (fence_i) begin
            r_state     <= S_FLUSH;
            r_cnt       <= '0;
            r_tag_wen   <= 1'b1;
            r_tag_wdata <= '0;
            r_req_rdy   <= 1'b0;
          end else if (cpu_req_valid) begin
            r_addr    <= cpu_req_addr;
            r_state   <= S_LOOKUP;
            r_req_rdy <= 1'b0;
          end
        end
        S_LOOKUP: begin
          if (w_hit) begin
            r_resp_dat <= w_hit_dw;
            r_resp_vld <= 1'b1;
            r_state    <= S_RESP;
          end else begin
            r_arvalid <= 1'b1;
            r_araddr  <= {r_addr[AW-1:OW], {OW{1'b0}}};
            r_state   <= S_MISS;
          end
        end
        S_MISS: begin
          if (mem_arready) begin
            r_arvalid <= 1'b0;
            r_state   <= S_REFILL;
          end
        end
        S_REFILL: begin
          if (w_done) begin
            r_tag_wen   <= 1'b1;
            r_data_wen  <= 1'b1;
            r_tag_wdata <= {1'b1, addr_tag(r_addr)};
            r_state     <= S_WRITE;
          end
        end
        S_WRITE: begin
          r_tag_wen  <= 1'b0;
          r_data_wen <= 1'b0;
          r_resp_dat <= w_fill_dw;
          r_resp_vld <= 1'b1;
          r_state    <= S_RESP;
        end
        S_RESP: begin
          if (cpu_resp_ready) begin
            r_resp_vld <= 1'b0;
            r_req_rdy  <= 1'b1;
            r_state    <= S_IDLE;
          end
        end
        S_FLUSH: begin
          r_cnt <= r_cnt + IW'(1);
          // raise done one cycle early so it lines up with the set-63 write
          if (r_cnt == IW'(62)) r_fence_done <= 1'b1;
          if (r_cnt == {IW{1'b1}}) begin
            r_tag_wen <= 1'b0;
            r_req_rdy <= 1'b1;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign set_index      = (r_state == S_FLUSH) ? r_cnt : r_addr[OW+IW-1:OW];
  assign cpu_req_ready  = r_req_rdy;
  assign cpu_resp_valid = r_resp_vld;
  assign cpu_resp_data  = r_resp_dat;
  assign fence_done     = r_fence_done;
  assign mem_arvalid    = r_arvalid;
  assign mem_araddr     = r_araddr;
  assign tag_wen        = r_tag_wen;
  assign tag_wdata      = r_tag_wdata;
  assign data_wen       = r_data_wen;
  assign data_wdata     = w_line;

endmodule

// File: tb/tb_ysyx_22050598_icache_ctrl.sv
// Directed bench with scoreboard queues for responses, refill addresses and array writes.
module tb_ysyx_22050598_icache_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         cpu_req_valid = 1'b0, cpu_req_ready;
  logic [63:0]  cpu_req_addr = '0;
  logic         cpu_resp_valid, cpu_resp_ready = 1'b1;
  logic [63:0]  cpu_resp_data;
  logic         fence_i = 1'b0, fence_done;
  logic [5:0]   set_index;
  logic         tag_wen, data_wen;
  logic [54:0]  tag_wdata, tag_rdata;
  logic [127:0] data_wdata, data_rdata;
  logic         mem_arvalid, mem_arready = 1'b0;
  logic [63:0]  mem_araddr;
  logic         mem_rvalid = 1'b0, mem_rlast = 1'b0;
  logic [63:0]  mem_rdata = '0;

  int vecs = 0;
  int errs = 0;
  int done_cnt = 0;

  logic [63:0]  exp_resp[$];
  logic [63:0]  exp_ar[$];
  logic [60:0]  exp_tw[$];
  logic [133:0] exp_dw[$];

  logic [54:0]  tag_mem[64];
  logic [127:0] data_mem[64];

  always #5 clk = ~clk;

  ysyx_22050598_icache_ctrl dut (
    .clk(clk), .rst(rst),
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready), .cpu_req_addr(cpu_req_addr),
    .cpu_resp_valid(cpu_resp_valid), .cpu_resp_ready(cpu_resp_ready), .cpu_resp_data(cpu_resp_data),
    .fence_i(fence_i), .fence_done(fence_done), .set_index(set_index),
    .tag_wen(tag_wen), .tag_wdata(tag_wdata), .tag_rdata(tag_rdata),
    .data_wen(data_wen), .data_wdata(data_wdata), .data_rdata(data_rdata),
    .mem_arvalid(mem_arvalid), .mem_arready(mem_arready), .mem_araddr(mem_araddr),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_rlast(mem_rlast)
  );

  // external tag/valid and data arrays: combinational read, clocked write
  assign tag_rdata  = tag_mem[set_index];
  assign data_rdata = data_mem[set_index];
  always @(posedge clk) begin
    if (tag_wen)  tag_mem[set_index]  <= tag_wdata;
    if (data_wen) data_mem[set_index] <= data_wdata;
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic miss_q(input string nm);
    vecs++;
    errs++;
    $display("FAIL %s: DUT output with no expected entry queued", nm);
  endtask

  // monitor: pops and compares whenever the DUT presents an output event
  always @(negedge clk) begin
    if (rst) begin
      if (cpu_resp_valid && cpu_resp_ready) begin
        if (exp_resp.size() == 0) miss_q("resp_unexpected");
        else chk("resp_data", 128'(cpu_resp_data), 128'(exp_resp.pop_front()));
      end
      if (tag_wen) begin
        if (exp_tw.size() == 0) miss_q("tag_write_unexpected");
        else chk("tag_write", 128'({set_index, tag_wdata}), 128'(exp_tw.pop_front()));
      end
      if (data_wen) begin
        if (exp_dw.size() == 0) miss_q("data_write_unexpected");
        else chk("data_write", 128'({set_index, data_wdata} >> 0), exp_dw[0][127:0]);
        if (exp_dw.size() != 0) chk("data_write_idx", 128'(set_index), 128'(exp_dw.pop_front() >> 128));
      end
      if (mem_arvalid && mem_arready) begin
        if (exp_ar.size() == 0) miss_q("araddr_unexpected");
        else chk("mem_araddr", 128'(mem_araddr), 128'(exp_ar.pop_front()));
      end
      if (fence_done) begin
        chk("fence_done_on_set63", 128'({tag_wen, set_index}), 128'({1'b1, 6'd63}));
        done_cnt++;
      end
    end
  end

  task automatic bus_cycle_ar(input logic [63:0] b0, input logic [63:0] b1, input bit full);
    int n = 0;
    @(negedge clk);
    while (!mem_arvalid && n < 50) begin n++; @(negedge clk); end
    if (!mem_arvalid) chk("arvalid_timeout", 128'(mem_arvalid), 128'(1));
    @(posedge clk); #1 mem_arready = 1'b1;
    @(posedge clk); #1 mem_arready = 1'b0; mem_rvalid = 1'b1; mem_rdata = b0; mem_rlast = 1'b0;
    if (full) begin
      @(posedge clk); #1 mem_rdata = b1; mem_rlast = 1'b1;
      @(posedge clk); #1 mem_rvalid = 1'b0; mem_rlast = 1'b0;
    end
  endtask

  task automatic issue(input logic [63:0] addr);
    int n = 0;
    @(posedge clk); #1 cpu_req_valid = 1'b1; cpu_req_addr = addr;
    @(negedge clk);
    while (!cpu_req_ready && n < 50) begin n++; @(negedge clk); end
    @(posedge clk); #1 cpu_req_valid = 1'b0;
  endtask

  task automatic fetch(input logic [63:0] addr, input bit miss, input logic [63:0] b0,
                       input logic [63:0] b1, input logic [63:0] exp, input int hold);
    int  n = 0;
    bit  saw_ar = 1'b0;
    exp_resp.push_back(exp);
    if (miss) begin
      exp_ar.push_back({addr[63:4], 4'h0});
      exp_tw.push_back({addr[9:4], 1'b1, addr[63:10]});
      exp_dw.push_back({addr[9:4], b1, b0});
    end
    cpu_resp_ready = (hold == 0);
    issue(addr);
    if (miss) bus_cycle_ar(b0, b1, 1'b1);
    do begin
      @(negedge clk);
      n++;
      saw_ar |= mem_arvalid;
    end while (!cpu_resp_valid && n < 60);
    if (!cpu_resp_valid) chk("resp_timeout", 128'(cpu_resp_valid), 128'(1));
    if (!miss) begin
      chk("hit_latency", 128'(n), 128'(2));
      chk("hit_no_arvalid", 128'(saw_ar), 128'(0));
    end
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        chk("hold_stable", 128'({cpu_resp_valid, cpu_req_ready, cpu_resp_data}), 128'({1'b1, 1'b0, exp}));
        @(negedge clk);
      end
      @(posedge clk); #1 cpu_resp_ready = 1'b1;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    for (int i = 0; i < 64; i++) begin tag_mem[i] = '0; data_mem[i] = '0; end
    repeat (2) @(negedge clk);
    chk("rst_ctrl", 128'({cpu_req_ready, cpu_resp_valid, fence_done, mem_arvalid, tag_wen, data_wen}), 128'(6'b100000));
    chk("rst_data", 128'({cpu_resp_data, mem_araddr}), 128'(0));
    chk("rst_arrays", {set_index, tag_wdata, data_wdata[66:0]} | data_wdata, 128'(0));
    rst = 1'b1;

    fetch(64'h8000_0000, 1'b1, 64'h1111, 64'h2222, 64'h1111, 0);
    fetch(64'h8000_0008, 1'b0, '0, '0, 64'h2222, 0);
    fetch(64'h8000_0000, 1'b0, '0, '0, 64'h1111, 5);
    fetch(64'h8000_0400, 1'b1, 64'h3333, 64'h4444, 64'h3333, 0);
    fetch(64'h8000_0008, 1'b1, 64'h1111, 64'h2222, 64'h2222, 0);
    fetch(64'h8000_0018, 1'b1, 64'h5555, 64'h6666, 64'h6666, 0);
    fetch(64'h8000_0010, 1'b0, '0, '0, 64'h5555, 0);

    // fence together with a request: sweep all sets, request dropped
    for (int i = 0; i < 64; i++) exp_tw.push_back({6'(i), 55'h0});
    @(posedge clk); #1 fence_i = 1'b1; cpu_req_valid = 1'b1; cpu_req_addr = 64'h8000_0010;
    @(negedge clk);
    chk("fence_req_ready", 128'(cpu_req_ready), 128'(1));
    @(posedge clk); #1 fence_i = 1'b0; cpu_req_valid = 1'b0;
    n = 0;
    while (done_cnt == 0 && n < 100) begin n++; @(posedge clk); end
    chk("fence_done_seen", 128'(done_cnt), 128'(1));
    #1;
    @(negedge clk);
    chk("fence_idle", 128'({cpu_req_ready, tag_wen, cpu_resp_valid}), 128'(3'b100));
    chk("fence_writes_left", 128'(exp_tw.size()), 128'(0));
    fetch(64'h8000_0008, 1'b1, 64'h9999, 64'haaaa, 64'haaaa, 0);

    // reset in the middle of a refill, after beat 0
    exp_ar.push_back(64'h8000_0010);
    issue(64'h8000_0010);
    bus_cycle_ar(64'hbeef, 64'h0, 1'b0);
    @(posedge clk); #1 rst = 1'b0; mem_rvalid = 1'b0;
    #1;
    chk("arst_ctrl", 128'({cpu_req_ready, cpu_resp_valid, fence_done, mem_arvalid, tag_wen, data_wen}), 128'(6'b100000));
    chk("arst_line", data_wdata, 128'(0));
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1 mem_rvalid = 1'b1; mem_rdata = 64'hdead; mem_rlast = 1'b1;
    @(posedge clk); #1 mem_rvalid = 1'b0; mem_rlast = 1'b0;
    @(negedge clk);
    chk("stray_beat", 128'({mem_arvalid, cpu_req_ready, data_wdata}), 128'({2'b01, 128'h0}));
    fetch(64'h8000_0010, 1'b1, 64'h7777, 64'h8888, 64'h7777, 0);

    repeat (3) @(negedge clk);
    chk("queues_empty", 128'({exp_resp.size(), exp_ar.size(), exp_tw.size(), exp_dw.size()}), 128'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/ysyx_22050598_icache_ctrl.md
# ysyx_22050598_icache_ctrl

Direct-mapped instruction-cache controller that sits directly upstream of the cache tag/valid array and the line data array. It accepts fetch requests and drives the array's set index and write port. It compares the stored tag/valid entry, refills 16-byte lines from memory in two 64-bit beats on a miss, and sweeps all sets on a fence.i.

## Interface
Parameters:
- AW, 64, fetch address width
- OW, 4, line offset bits (16-byte line)
- IW, 6, set index bits (64 sets)
- TW, AW-IW-OW = 54, tag bits
- DW, TW+1 = 55, tag/valid entry width: bit DW-1 is valid, [TW-1:0] is tag
- LW, 128, line width

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- cpu_req_valid  in  1  fetch request
- cpu_req_ready  out  1  controller can accept a request
- cpu_req_addr  in  AW  fetch address; bits [2:0] ignored
- cpu_resp_valid  out  1  response valid
- cpu_resp_ready  in  1  consumer accepts response
- cpu_resp_data  out  64  instruction doubleword
- fence_i  in  1  invalidate-all request, one-cycle pulse
- fence_done  out  1  one-cycle pulse when the sweep completes
- set_index  out  IW  index to tag and data arrays
- tag_wen  out  1  tag/valid write enable
- tag_wdata  out  DW  tag/valid write data
- tag_rdata  in  DW  combinational tag/valid read at set_index
- data_wen  out  1  line write enable
- data_wdata  out  LW  line write data
- data_rdata  in  LW  combinational line read at set_index
- mem_arvalid  out  1  refill address valid
- mem_arready  in  1  memory accepts address
- mem_araddr  out  AW  line-aligned address, low OW bits zero
- mem_rvalid  in  1  refill beat valid
- mem_rdata  in  64  refill beat; the first beat is the low doubleword
- mem_rlast  in  1  final beat marker

## Operation
States: IDLE, LOOKUP, MISS, REFILL, WRITE, RESP, FLUSH.
- IDLE:
  - cpu_req_ready=1.
  - fence_i has priority over cpu_req_valid in the same cycle. fence_i clears the counter and goes to FLUSH; cpu_req_ready is still 1 in that cycle, but the request is not accepted.
  - On a request handshake: register the address, go to LOOKUP.
- LOOKUP:
  - set_index = addr[OW+IW-1:OW].
  - Hit when tag_rdata[DW-1]=1 and tag_rdata[TW-1:0]=addr[AW-1:OW+IW].
  - On a hit: latch the data_rdata doubleword selected by addr[3] (0 selects the low doubleword) into the response register, go to RESP.
  - On a miss: go to MISS.
- MISS: hold mem_arvalid=1 with mem_araddr = {addr[AW-1:OW], 0} until mem_arready, then go to REFILL.
- REFILL:
  - Beat 0 goes into buffer[63:0], beat 1 into buffer[127:64], using a 1-bit beat counter.
  - On the beat with mem_rlast, go to WRITE.
  - mem_rvalid outside REFILL is ignored.
- WRITE:
  - One cycle: tag_wen=1, data_wen=1, tag_wdata = {1'b1, tag}, data_wdata = buffer.
  - The response is taken from the buffer doubleword selected by addr[3]; go to RESP.
- RESP:
  - cpu_resp_valid=1 and cpu_resp_data held stable until cpu_resp_ready.
  - On the handshake, go to IDLE.
- FLUSH:
  - Counter 0..63 drives set_index; tag_wen=1, tag_wdata=0, one set per cycle.
  - After set 63: fence_done=1 for one cycle, go to IDLE.
  - The data array is not written during the sweep.
- fence_i outside IDLE is ignored; the issuer holds it until cpu_req_ready is seen.
- Outside LOOKUP/WRITE/FLUSH, set_index = registered index and both write enables are 0.

## Timing
- Reset values: state IDLE; cpu_req_ready=1, cpu_resp_valid=0, cpu_resp_data=0, fence_done=0, mem_arvalid=0, mem_araddr=0, tag_wen=0, data_wen=0, set_index=0, tag_wdata=0, data_wdata=0.
- Reset during any state aborts the operation. Outputs take reset values asynchronously, and nothing partial is written to the arrays.
- Hit latency: request handshake at cycle 0, LOOKUP at cycle 1, cpu_resp_valid from cycle 2.
- Miss latency: cycle 2 mem_arvalid, plus arready wait, plus two beats, plus 1 WRITE cycle, then RESP.
- Flush: 64 write cycles, with fence_done in the last of them; IDLE follows.
- All outputs are driven from state or registers; only set_index depends combinationally on state.

## Structure
- Shared package ysyx_22050598_cache_pkg: state enum, the OW/IW/TW/DW/LW constants, and the valid-bit position.
- Optional sub-module ysyx_22050598_cache_refill_buf: 2-beat collector with beat counter, done flag, and 128-bit line output.
- The tag/valid array and the data array are external instances, connected at the top level.

## Test plan
- After reset, fetch 0x8000_0000: miss. mem_araddr=0x8000_0000 is required. Beats 0x1111, then 0x2222 with rlast. Expected: tag write of {1, 0x8000_0000>>10}, response 0x1111.
- Fetch 0x8000_0008 next: hit. Response 0x2222 two cycles after the handshake, with no mem_arvalid.
- Fetch 0x8000_0400 (same set 0, different tag): miss. The refill overwrites set 0, and a subsequent fetch of 0x8000_0000 misses again.
- Hold cpu_resp_ready=0 for 5 cycles on a hit: cpu_resp_valid and cpu_resp_data stay stable, and cpu_req_ready stays 0.
- Assert fence_i and cpu_req_valid together in IDLE: the request is not accepted. Expect 64 consecutive tag writes of 0 on sets 0..63, then fence_done, and the prior line now misses.
- Assert rst mid-REFILL after beat 0: no tag_wen or data_wen, mem_arvalid=0, and a stray beat after reset has no effect. Re-fetching the address causes a fresh miss.
